// File: rtl/cpu_pkg.sv
// Shared core types: IF/ID pipeline record, NOP encoding and fetch helpers.
// Also used by the decode stage; fetch_stage's FETCH_PERF_CNT_EN build does not change this file.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;     // PC+4 of the captured instruction
    logic [31:0] instr;
    logic        valid;  // 0 marks a bubble
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  // One action is chosen per edge, in priority order redirect > fault > stall > advance
  typedef enum logic [1:0] {
    FETCH_ADVANCE  = 2'd0,
    FETCH_STALL    = 2'd1,
    FETCH_FAULT    = 2'd2,
    FETCH_REDIRECT = 2'd3
  } fetch_action_e;

  // Range test is done on the word index so byte offsets never matter
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} < words;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction memory bus, hazard/branch inputs and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the fetch/stall performance counter outputs.
interface fetch_stage_if;

  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic        fetch_fault_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o;
  logic [31:0] stall_count_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, imem_instr_i,
    output imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_fault_o,
    output fetch_count_o, stall_count_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, imem_instr_i,
    input  imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_fault_o,
    input  fetch_count_o, stall_count_o
  );
`else
  modport master (
    input  stall_i, branch_taken_i, branch_target_i, imem_instr_i,
    output imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_fault_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, imem_instr_i,
    input  imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_fault_o
  );
`endif

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a new record, hold, or insert a bubble.
// Bubble wins over load; asynchronous reset leaves a bubble.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clock,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= IFID_BUBBLE;
    end else if (bubble) begin
      q_reg <= IFID_BUBBLE;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, redirect, stall and out-of-range fault protection.
// Optional FETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1025
) (
  input  logic          clock,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  logic [31:0]   pc_reg;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic [31:0]   aligned_target;
  logic          fault_reg;
  logic          fault_next;
  logic          out_of_range;
  logic          target_in_range;
  logic          ifid_load;
  logic          ifid_bubble;
  ifid_t         ifid_d;
  ifid_t         ifid_q;
  fetch_action_e action;

  assign pc_plus4        = pc_reg + 32'(WORD_BYTES);
  assign aligned_target  = {bus.branch_target_i[31:2], 2'b00};
  assign out_of_range    = !word_in_range(pc_reg, IMEM_WORDS);
  assign target_in_range = word_in_range(aligned_target, IMEM_WORDS);

  always_comb begin
    action = FETCH_ADVANCE;
    if (bus.branch_taken_i) begin
      action = FETCH_REDIRECT;
    end else if (out_of_range) begin
      action = FETCH_FAULT;
    end else if (bus.stall_i) begin
      action = FETCH_STALL;
    end
  end

  always_comb begin
    pc_next     = pc_reg;
    fault_next  = fault_reg;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (action)
      FETCH_REDIRECT: begin
        pc_next     = aligned_target;
        ifid_bubble = 1'b1;
        // An out-of-range target keeps the fault; the next edge re-asserts it anyway
        if (target_in_range) begin
          fault_next = 1'b0;
        end
      end
      FETCH_FAULT: begin
        fault_next  = 1'b1;
        ifid_bubble = 1'b1;
      end
      FETCH_ADVANCE: begin
        pc_next   = pc_plus4;
        ifid_load = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  assign ifid_d = '{pc: pc_plus4, instr: bus.imem_instr_i, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign bus.imem_addr_o   = pc_reg;
  assign bus.ifid_pc_o     = ifid_q.pc;
  assign bus.ifid_instr_o  = ifid_q.instr;
  assign bus.ifid_valid_o  = ifid_q.valid;
  assign bus.fetch_fault_o = fault_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] stall_count_reg;

  // Stalls count even while faulted; only a redirect suppresses them
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= 32'h0;
      stall_count_reg <= 32'h0;
    end else begin
      if ((action == FETCH_ADVANCE) && (fetch_count_reg != 32'hFFFF_FFFF)) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (bus.stall_i && !bus.branch_taken_i && (stall_count_reg != 32'hFFFF_FFFF)) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
    end
  end

  assign bus.fetch_count_o = fetch_count_reg;
  assign bus.stall_count_o = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage (IMEM_WORDS=47); checks counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    int          id;
  } exp_t;

  logic clock;
  logic rst_n;
  int   checks;
  int   fails;
  int   step_id;
  exp_t exp_q[$];

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (47)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational instruction memory: word 0 is MOV r0,#20, others tag their address
  function automatic logic [31:0] instr_at(input logic [31:0] addr);
    if (addr[31:2] == 30'd0) return 32'hE3A0_0014;
    return 32'hE000_0000 | addr;
  endfunction

  assign bus.imem_instr_i = instr_at(bus.imem_addr_o);

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s step %0d: got %h, required %h", nm, id, act, req);
    end else begin
      $display("ok   %s step %0d: %h", nm, id, act);
    end
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei,
                      input logic ev, input logic ef);
    exp_t e;
    @(negedge clock);
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    e.addr = ea; e.ipc = ep; e.instr = ei; e.valid = ev; e.fault = ef; e.id = step_id;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic advance_from(input logic [31:0] p);
    step(1'b0, 1'b0, 32'h0, p + 32'd4, p + 32'd4, instr_at(p), 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("queue_drained", step_id, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: one expected record per edge, compared just after the edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("imem_addr", e.id, bus.imem_addr_o, e.addr);
      chk("ifid_pc", e.id, bus.ifid_pc_o, e.ipc);
      chk("ifid_instr", e.id, bus.ifid_instr_o, e.instr);
      chk("ifid_valid", e.id, 32'(bus.ifid_valid_o), 32'(e.valid));
      chk("fetch_fault", e.id, 32'(bus.fetch_fault_o), 32'(e.fault));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    fails   = 0;
    step_id = 0;
    rst_n   = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = 32'h0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_imem_addr", -1, bus.imem_addr_o, 32'h0);
    chk("rst_ifid_pc", -1, bus.ifid_pc_o, 32'h0);
    chk("rst_ifid_instr", -1, bus.ifid_instr_o, NOP_INSTR);
    chk("rst_ifid_valid", -1, 32'(bus.ifid_valid_o), 32'd0);
    chk("rst_fault", -1, 32'(bus.fetch_fault_o), 32'd0);
    #1 rst_n = 1'b1;

    // First fetch and the next one
    step(1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE000_0004, 1'b1, 1'b0);
    // Three-cycle stall at pc=8, then resume
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE000_0004, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'hC, 32'hC, 32'hE000_0008, 1'b1, 1'b0);
    // Redirect together with stall
    step(1'b1, 1'b1, 32'h90, 32'h90, 32'h0, NOP_INSTR, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h94, 32'h94, 32'hE000_0090, 1'b1, 1'b0);
    // Unaligned target gets word-aligned
    step(1'b0, 1'b1, 32'h92, 32'h90, 32'h0, NOP_INSTR, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h94, 32'h94, 32'hE000_0090, 1'b1, 1'b0);
    // Self-branch loop at 0x94
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h94, 32'h94, 32'h0, NOP_INSTR, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h98, 32'h98, 32'hE000_0094, 1'b1, 1'b0);
    end
    // Free-run to the end of the 47-word memory
    for (logic [31:0] p = 32'h98; p <= 32'hB8; p += 32'd4)
      advance_from(p);
    step(1'b0, 1'b0, 32'h0, 32'hBC, 32'h0, NOP_INSTR, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'hBC, 32'h0, NOP_INSTR, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'hBC, 32'h0, NOP_INSTR, 1'b0, 1'b1);
    // Redirect out of the fault
    step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'hE3A0_0014, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE000_0004, 1'b1, 1'b0);
    drain();

    // Asynchronous reset mid-cycle clears IF/ID immediately
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_imem_addr", -2, bus.imem_addr_o, 32'h0);
    chk("midrst_ifid_pc", -2, bus.ifid_pc_o, 32'h0);
    chk("midrst_ifid_instr", -2, bus.ifid_instr_o, NOP_INSTR);
    chk("midrst_ifid_valid", -2, 32'(bus.ifid_valid_o), 32'd0);
    bus.stall_i        = 1'b0;
    bus.branch_taken_i = 1'b0;
    @(posedge clock);
    #2 rst_n = 1'b1;

    // 10 advances, 3 stalls, 1 redirect during stall
    for (int i = 0; i < 10; i++)
      advance_from(32'(i * 4));
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'h0, 32'h28, 32'h28, 32'hE000_0024, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h10, 32'h10, 32'h0, NOP_INSTR, 1'b0, 1'b0);
    drain();
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", step_id, bus.fetch_count_o, 32'd10);
    chk("stall_count", step_id, bus.stall_count_o, 32'd3);
`endif
    bus.stall_i        = 1'b0;
    bus.branch_taken_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
